// File: rtl/ro_puf_ctrl_if.sv
// Host-side challenge/response interface of the ring-oscillator PUF controller.
// The host drives start/challenge; the controller returns status and response bits.
interface ro_puf_ctrl_if #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned NBITS = 8
) ();
  logic             start;
  logic [SEL_W-1:0] chal_a;
  logic [SEL_W-1:0] chal_b;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] response;
  logic             err;
  logic [NBITS-1:0] tie_mask;

  modport master (
    output start, chal_a, chal_b,
    input  busy, done, response, err, tie_mask
  );

  modport slave (
    input  start, chal_a, chal_b,
    output busy, done, response, err, tie_mask
  );
endinterface

// File: rtl/ro_puf_ctrl.sv
// Sequencer for the RO PUF array: per response bit it selects a pair, settles, counts and compares.
// Optional RO_PUF_TIE_FLAG_EN builds the per-bit count-tie flags; otherwise tie_mask is tied to 0.
module ro_puf_ctrl #(
  parameter int unsigned NUM_RO = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned NBITS  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 8,
  parameter int unsigned WINDOW = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  ro_puf_ctrl_if.slave     host,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic [SEL_W-1:0] ro_sel_a,
  output logic [SEL_W-1:0] ro_sel_b,
  output logic             ro_en
);

  localparam int unsigned IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(NBITS - 1);
  localparam logic [TMR_W-1:0] SettleEnd = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WindowEnd = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCount,
    StCmp,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [NBITS-1:0] resp_q, resp_d;
  logic             err_q, err_d;

  // Bits [1:0] are the synchronizer, bit [2] is the history flop for edge detection.
  logic [2:0]       sync_a_q, sync_b_q;

  logic             accept;
  logic             rise_a, rise_b;
  logic             pair_same;
  logic [SEL_W-1:0] next_sel_a, next_sel_b;

  assign accept     = (state_q == StIdle) && host.start;
  assign rise_a     = sync_a_q[1] & ~sync_a_q[2];
  assign rise_b     = sync_b_q[1] & ~sync_b_q[2];
  assign pair_same  = (sel_a_q == sel_b_q);
  assign next_sel_a = SEL_W'((32'(sel_a_q) + 32'd1) % NUM_RO);
  assign next_sel_b = SEL_W'((32'(sel_b_q) + 32'd1) % NUM_RO);

  // Synchronizers sample continuously, independent of the sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[1:0], ro_a};
      sync_b_q <= {sync_b_q[1:0], ro_b};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    resp_d  = resp_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (host.start) begin
          sel_a_d = host.chal_a;
          sel_b_d = host.chal_b;
          idx_d   = '0;
          tmr_d   = '0;
          resp_d  = '0;
          err_d   = 1'b0;
          state_d = StSettle;
        end
      end

      StSettle: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        if (tmr_q == SettleEnd) begin
          tmr_d   = '0;
          state_d = StCount;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      StCount: begin
        if (rise_a && (cnt_a_q != CntMax)) cnt_a_d = cnt_a_q + 1'b1;
        if (rise_b && (cnt_b_q != CntMax)) cnt_b_d = cnt_b_q + 1'b1;
        if (tmr_q == WindowEnd) begin
          tmr_d   = '0;
          state_d = StCmp;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      StCmp: begin
        // A pair comparing an oscillator with itself carries no entropy: force 0, flag it.
        resp_d[idx_q] = (cnt_a_q > cnt_b_q) && !pair_same;
        if (pair_same) err_d = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          sel_a_d = next_sel_a;
          sel_b_d = next_sel_b;
          state_d = StSettle;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tmr_q   <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

`ifdef RO_PUF_TIE_FLAG_EN
  logic [NBITS-1:0] tie_q, tie_d;

  always_comb begin
    tie_d = tie_q;
    if (accept) begin
      tie_d = '0;
    end else if (state_q == StCmp) begin
      tie_d[idx_q] = (cnt_a_q == cnt_b_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_q <= '0;
    end else begin
      tie_q <= tie_d;
    end
  end

  assign host.tie_mask = tie_q;
`else
  assign host.tie_mask = '0;
`endif

  assign ro_sel_a      = sel_a_q;
  assign ro_sel_b      = sel_b_q;
  assign ro_en         = (state_q == StSettle) || (state_q == StCount);
  assign host.busy     = (state_q == StSettle) || (state_q == StCount) || (state_q == StCmp);
  assign host.done     = (state_q == StDone);
  assign host.response = resp_q;
  assign host.err      = err_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl: randomized oscillator waveforms and challenges checked
// against an edge-counting reference model built from the recorded oscillator samples.
module tb_ro_puf_ctrl;

  localparam int unsigned SEL_W = 4;
  localparam int M_NB = 4;
  localparam int M_S  = 2;
  localparam int M_W  = 16;
  localparam int M_CW = 16;
  localparam int S_NB = 2;
  localparam int S_S  = 2;
  localparam int S_W  = 64;
  localparam int S_CW = 4;
  localparam int MAXC = 8000;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  logic ro_a   = 1'b0;
  logic ro_b   = 1'b0;

  logic [SEL_W-1:0] m_sel_a, m_sel_b, s_sel_a, s_sel_b;
  logic             m_ro_en, s_ro_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic samp_a [MAXC];
  logic samp_b [MAXC];

  // Oscillator generator config: half-periods in clk cycles; mode 0 independent,
  // 1 ro_b copies ro_a, 2 ro_b held low.
  int ha = 2, hb = 4, mode = 0;
  int ta = 1, tb_left = 1;

  ro_puf_ctrl_if #(.SEL_W(SEL_W), .NBITS(M_NB)) hm ();
  ro_puf_ctrl_if #(.SEL_W(SEL_W), .NBITS(S_NB)) hs ();

  ro_puf_ctrl #(
    .NUM_RO(16), .SEL_W(SEL_W), .NBITS(M_NB), .CNT_W(M_CW), .SETTLE(M_S), .WINDOW(M_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (hm),
    .ro_a    (ro_a),
    .ro_b    (ro_b),
    .ro_sel_a(m_sel_a),
    .ro_sel_b(m_sel_b),
    .ro_en   (m_ro_en)
  );

  ro_puf_ctrl #(
    .NUM_RO(16), .SEL_W(SEL_W), .NBITS(S_NB), .CNT_W(S_CW), .SETTLE(S_S), .WINDOW(S_W)
  ) dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (hs),
    .ro_a    (ro_a),
    .ro_b    (ro_b),
    .ro_sel_a(s_sel_a),
    .ro_sel_b(s_sel_b),
    .ro_en   (s_ro_en)
  );

  always #5 if (clk_en) clk = ~clk;

  // Edge index k is the value of cyc just before posedge k; samp_*[k] is what that edge saw.
  always @(posedge clk) begin
    if (cyc < MAXC) begin
      samp_a[cyc] <= ro_a;
      samp_b[cyc] <= ro_b;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ta <= 1) begin
      ro_a <= ~ro_a;
      ta   <= ha;
    end else begin
      ta <= ta - 1;
    end
    case (mode)
      0: begin
        if (tb_left <= 1) begin
          ro_b    <= ~ro_b;
          tb_left <= hb;
        end else begin
          tb_left <= tb_left - 1;
        end
      end
      1: ro_b <= (ta <= 1) ? ~ro_a : ro_a;
      default: ro_b <= 1'b0;
    endcase
  end

  task automatic drive(input bit sat, input logic st, input logic [SEL_W-1:0] ca,
                       input logic [SEL_W-1:0] cb);
    if (sat) begin
      hs.start = st; hs.chal_a = ca; hs.chal_b = cb;
    end else begin
      hm.start = st; hm.chal_a = ca; hm.chal_b = cb;
    end
  endtask

  task automatic observe(input bit sat, output logic [SEL_W-1:0] sa, output logic [SEL_W-1:0] sb,
                         output logic en, output logic bsy, output logic dn, output logic er,
                         output logic [31:0] rsp, output logic [31:0] tie);
    if (sat) begin
      sa = s_sel_a; sb = s_sel_b; en = s_ro_en; bsy = hs.busy; dn = hs.done; er = hs.err;
      rsp = 32'(hs.response); tie = 32'(hs.tie_mask);
    end else begin
      sa = m_sel_a; sb = m_sel_b; en = m_ro_en; bsy = hm.busy; dn = hm.done; er = hm.err;
      rsp = 32'(hm.response); tie = 32'(hm.tie_mask);
    end
  endtask

  task automatic set_gen(input int a, input int b, input int m);
    @(posedge clk);
    #1;
    ha = a; hb = b; mode = m;
  endtask

  // One full challenge: checks per-cycle selects/enable/busy, done latency and the final result.
  task automatic run_check(input string name, input bit sat, input logic [SEL_W-1:0] ca,
                           input logic [SEL_W-1:0] cb, input bit poke,
                           output logic [31:0] resp_o, output logic err_o,
                           output logic [31:0] tie_o);
    int nb, s, w, cmax, per, e0, last;
    logic [SEL_W-1:0] sa, sb, xa, xb;
    logic en, bsy, dn, er;
    logic [31:0] rsp, tie, exp_resp, exp_tie, held;
    logic exp_err;
    nb   = sat ? S_NB : M_NB;
    s    = sat ? S_S : M_S;
    w    = sat ? S_W : M_W;
    cmax = sat ? ((1 << S_CW) - 1) : ((1 << M_CW) - 1);
    per  = s + w + 1;
    last = nb * per + 1;
    @(negedge clk);
    drive(sat, 1'b1, ca, cb);
    @(posedge clk);
    #1;
    e0 = cyc - 1;
    drive(sat, 1'b0, SEL_W'($urandom), SEL_W'($urandom));
    held = '0;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      observe(sat, sa, sb, en, bsy, dn, er, rsp, tie);
      if (n < last) begin
        int i, p;
        i  = (n - 1) / per;
        p  = (n - 1) % per;
        xa = ca + SEL_W'(i);
        xb = cb + SEL_W'(i);
        checks++;
        if (sa !== xa || sb !== xb) begin
          errors++;
          $display("FAIL %s sel n=%0d got %0d/%0d want %0d/%0d", name, n, sa, sb, xa, xb);
        end
        checks++;
        if (en !== 1'(p < s + w) || bsy !== 1'b1 || dn !== 1'b0) begin
          errors++;
          $display("FAIL %s ctl n=%0d got en=%b busy=%b done=%b want en=%b busy=1 done=0",
                   name, n, en, bsy, dn, 1'(p < s + w));
        end
        if (poke) drive(sat, 1'((n % 7) == 3), SEL_W'($urandom), SEL_W'($urandom));
      end else begin
        drive(sat, 1'b0, ca, cb);
        checks++;
        if (dn !== 1'b1 || bsy !== 1'b0 || en !== 1'b0) begin
          errors++;
          $display("FAIL %s latency n=%0d got done=%b busy=%b en=%b want done=1 busy=0 en=0",
                   name, n, dn, bsy, en);
        end
        exp_resp = '0;
        exp_tie  = '0;
        exp_err  = 1'b0;
        for (int b = 0; b < nb; b++) begin
          int base, na, nbc;
          logic [SEL_W-1:0] pa, pb;
          base = e0 + b * per;
          na   = 0;
          nbc  = 0;
          pa   = ca + SEL_W'(b);
          pb   = cb + SEL_W'(b);
          // A rise between samples e-3 and e-2 reaches the counter at edge e (2-cycle lag).
          for (int e = base + s + 1; e <= base + s + w; e++) begin
            if (samp_a[e-2] && !samp_a[e-3]) na++;
            if (samp_b[e-2] && !samp_b[e-3]) nbc++;
          end
          if (na > cmax) na = cmax;
          if (nbc > cmax) nbc = cmax;
          if (pa == pb) exp_err = 1'b1;
          else exp_resp[b] = (na > nbc);
`ifdef RO_PUF_TIE_FLAG_EN
          exp_tie[b] = (na == nbc);
`endif
        end
        checks++;
        if (rsp !== exp_resp) begin
          errors++;
          $display("FAIL %s response got %h want %h", name, rsp, exp_resp);
        end
        checks++;
        if (er !== exp_err) begin
          errors++;
          $display("FAIL %s err got %b want %b", name, er, exp_err);
        end
        checks++;
        if (tie !== exp_tie) begin
          errors++;
          $display("FAIL %s tie_mask got %h want %h", name, tie, exp_tie);
        end
        held = exp_resp;
      end
    end
    @(negedge clk);
    observe(sat, sa, sb, en, bsy, dn, er, rsp, tie);
    checks++;
    if (dn !== 1'b0 || bsy !== 1'b0 || rsp !== held) begin
      errors++;
      $display("FAIL %s after_done got done=%b busy=%b resp=%h want done=0 busy=0 resp=%h",
               name, dn, bsy, rsp, held);
    end
    resp_o = rsp;
    err_o  = er;
    tie_o  = tie;
  endtask

  task automatic test_reset();
    logic [SEL_W-1:0] sa, sb;
    logic en, bsy, dn, er;
    logic [31:0] rsp, tie;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    #3;
    for (int k = 0; k < 2; k++) begin
      observe(1'(k), sa, sb, en, bsy, dn, er, rsp, tie);
      checks++;
      if (sa !== '0 || sb !== '0 || en !== 1'b0 || bsy !== 1'b0 || dn !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctl dut%0d got sel=%0d/%0d en=%b busy=%b done=%b want all 0",
                 k, sa, sb, en, bsy, dn);
      end
      checks++;
      if (er !== 1'b0 || rsp !== '0 || tie !== '0) begin
        errors++;
        $display("FAIL reset_out dut%0d got err=%b resp=%h tie=%h want 0", k, er, rsp, tie);
      end
    end
    clk_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] r, t;
    logic e;
    set_gen(2, 4, 0);
    run_check("single", 1'b0, 4'd0, 4'd1, 1'b0, r, e, t);
    checks++;
    if (r[3:0] !== 4'b1111) begin
      errors++;
      $display("FAIL single_const got %b want 1111", r[3:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, t;
    logic e;
    logic [SEL_W-1:0] ca, cb;
    for (int k = 0; k < 6; k++) begin
      ca = SEL_W'($urandom);
      cb = ($urandom_range(0, 3) == 0) ? ca : SEL_W'($urandom);
      set_gen(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 0);
      run_check("random", 1'b0, ca, cb, 1'b0, r, e, t);
    end
  endtask

  task automatic test_wrap_err();
    logic [31:0] r, t;
    logic e;
    set_gen(1, 3, 0);
    run_check("wrap", 1'b0, 4'd15, 4'd15, 1'b0, r, e, t);
    checks++;
    if (e !== 1'b1 || r !== '0) begin
      errors++;
      $display("FAIL wrap_err got err=%b resp=%h want err=1 resp=0", e, r);
    end
  endtask

  task automatic test_tie();
    logic [31:0] r, t, want;
    logic e;
    set_gen(3, 3, 1);
    run_check("tie", 1'b0, 4'd4, 4'd9, 1'b0, r, e, t);
`ifdef RO_PUF_TIE_FLAG_EN
    want = 32'h0000_000f;
`else
    want = 32'h0;
`endif
    checks++;
    if (r !== '0 || t !== want) begin
      errors++;
      $display("FAIL tie_const got resp=%h tie=%h want resp=0 tie=%h", r, t, want);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] r, t, want;
    logic e;
    set_gen(1, 1, 2);
    run_check("sat", 1'b1, 4'd3, 4'd7, 1'b0, r, e, t);
    checks++;
    if (r[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL sat_const got %b want 11", r[1:0]);
    end
    // Both counters pinned at full scale must compare equal.
    set_gen(1, 1, 1);
    run_check("sat_both", 1'b1, 4'd5, 4'd6, 1'b0, r, e, t);
`ifdef RO_PUF_TIE_FLAG_EN
    want = 32'h3;
`else
    want = 32'h0;
`endif
    checks++;
    if (r !== '0 || t !== want) begin
      errors++;
      $display("FAIL sat_both_const got resp=%h tie=%h want resp=0 tie=%h", r, t, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, t;
    logic e;
    set_gen(2, 5, 0);
    run_check("busy_start", 1'b0, 4'd2, 4'd11, 1'b1, r, e, t);
    set_gen(5, 2, 0);
    run_check("back_to_back", 1'b0, 4'd13, 4'd6, 1'b0, r, e, t);
  endtask

  task automatic test_reset_mid();
    logic [SEL_W-1:0] sa, sb;
    logic en, bsy, dn, er;
    logic [31:0] rsp, tie, r, t;
    logic e;
    set_gen(1, 2, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd7, 4'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    repeat (M_S + 5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    observe(1'b0, sa, sb, en, bsy, dn, er, rsp, tie);
    checks++;
    if (en !== 1'b0 || bsy !== 1'b0 || dn !== 1'b0 || sa !== '0 || sb !== '0) begin
      errors++;
      $display("FAIL reset_mid_ctl got en=%b busy=%b done=%b sel=%0d/%0d want all 0",
               en, bsy, dn, sa, sb);
    end
    checks++;
    if (rsp !== '0 || er !== 1'b0 || tie !== '0) begin
      errors++;
      $display("FAIL reset_mid_out got resp=%h err=%b tie=%h want 0", rsp, er, tie);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_check("after_reset", 1'b0, 4'd7, 4'd1, 1'b0, r, e, t);
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_wrap_err();
    test_tie();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
